universal_register: RTL and testbench

Parametrised universal register: the next-generation replacement for the fixed 7-bit D register with asynchronous reset. It adds enable, synchronous clear, parallel load, logical shift left/right, rotate left/right and increment/decrement. It also provides serial in/out and a registered carry/shift-out flag. It is used as a general datapath storage, shift and count element.

---
 rtl/universal_register_if.sv | 26 ++
 rtl/universal_register.sv | 48 ++++
 tb/tb_universal_register.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/universal_register_if.sv
// universal_register_if: control, data and status bundle for universal_register
//   master drives en, sclr, mode, d, sin_l, sin_r and observes q, flag, sout_l, sout_r, zero;
//   slave is the register side.
interface universal_register_if #(
  parameter int WIDTH = 7
);
  logic             en;
  logic             sclr;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             flag;
  logic             sout_l;
  logic             sout_r;
  logic             zero;
  modport master (
    output en, sclr, mode, d, sin_l, sin_r,
    input  q, flag, sout_l, sout_r, zero
  );
  modport slave (
    input  en, sclr, mode, d, sin_l, sin_r,
    output q, flag, sout_l, sout_r, zero
  );
endinterface

// File: rtl/universal_register.sv
// universal_register: parametrised hold/load/shift/rotate/count register with serial I/O and carry flag
//   clk, reset (async, active-high); bus.slave carries en, sclr, mode, d, sin_l, sin_r in
//   and q, flag (registered), sout_l, sout_r, zero (combinational from q) out.
module universal_register #(
  parameter int               WIDTH       = 7,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic            clk,
  input logic            reset,
  universal_register_if.slave bus
);
  logic [WIDTH-1:0] q_n;
  logic             f_n;
  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;
  // one extra bit holds the wrap carry / borrow
  assign inc = {1'b0, bus.q} + (WIDTH+1)'(1);
  assign dec = {1'b0, bus.q} - (WIDTH+1)'(1);
  always_comb begin
    q_n = bus.q;
    f_n = bus.flag;
    case (bus.mode)
      3'b001: begin q_n = bus.d; f_n = 1'b0; end
      3'b010: begin q_n = {bus.q[WIDTH-2:0], bus.sin_l}; f_n = bus.q[WIDTH-1]; end
      3'b011: begin q_n = {bus.sin_r, bus.q[WIDTH-1:1]}; f_n = bus.q[0]; end
      3'b100: begin q_n = {bus.q[WIDTH-2:0], bus.q[WIDTH-1]}; f_n = bus.q[WIDTH-1]; end
      3'b101: begin q_n = {bus.q[0], bus.q[WIDTH-1:1]}; f_n = bus.q[0]; end
      3'b110: {f_n, q_n} = inc;
      3'b111: {f_n, q_n} = dec;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.q    <= RESET_VALUE;
      bus.flag <= 1'b0;
    end else if (bus.sclr) begin
      bus.q    <= RESET_VALUE;
      bus.flag <= 1'b0;
    end else if (bus.en) begin
      bus.q    <= q_n;
      bus.flag <= f_n;
    end
  end
  assign bus.sout_l = bus.q[WIDTH-1];
  assign bus.sout_r = bus.q[0];
  assign bus.zero   = bus.q == '0;
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: randomized + directed check of three universal_register instances against a reference model
module tb_universal_register;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  universal_register_if #(.WIDTH(7))  a ();
  universal_register_if #(.WIDTH(7))  b ();
  universal_register_if #(.WIDTH(16)) c ();
  universal_register #(.WIDTH(7), .RESET_VALUE(7'h00)) dut_a (.clk(clk), .reset(reset), .bus(a));
  universal_register #(.WIDTH(7), .RESET_VALUE(7'h55)) dut_b (.clk(clk), .reset(reset), .bus(b));
  universal_register #(.WIDTH(16), .RESET_VALUE(16'h0)) dut_c (.clk(clk), .reset(reset), .bus(c));
  int checks = 0;
  int failures = 0;
  int w [3] = '{7, 7, 16};
  longint unsigned rv [3] = '{64'h0, 64'h55, 64'h0};
  longint unsigned mq [3];
  logic mf [3];
  logic ven, vsclr, vsl, vsr;
  logic [2:0] vmode;
  logic [6:0] vd7;
  logic [15:0] vd16;
  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic en, input logic sclr, input logic [2:0] mode,
                       input logic [6:0] d7, input logic [15:0] d16, input logic sl, input logic sr);
    ven = en; vsclr = sclr; vmode = mode; vd7 = d7; vd16 = d16; vsl = sl; vsr = sr;
    a.en = en; a.sclr = sclr; a.mode = mode; a.d = d7;  a.sin_l = sl; a.sin_r = sr;
    b.en = en; b.sclr = sclr; b.mode = mode; b.d = d7;  b.sin_l = sl; b.sin_r = sr;
    c.en = en; c.sclr = sclr; c.mode = mode; c.d = d16; c.sin_l = sl; c.sin_r = sr;
  endtask
  // behavioural model: one clock edge of instance i in plain integer arithmetic
  task automatic model_step(input int i);
    longint unsigned m, x, top, bot, d;
    m = (64'd1 << w[i]) - 1;
    x = mq[i];
    top = (x >> (w[i] - 1)) & 1;
    bot = x & 1;
    d = (i == 2) ? longint'(vd16) : longint'(vd7);
    if (reset) begin mq[i] = rv[i]; mf[i] = 1'b0; end
    else if (vsclr) begin mq[i] = rv[i]; mf[i] = 1'b0; end
    else if (ven) begin
      case (vmode)
        3'd1: begin mq[i] = d & m; mf[i] = 1'b0; end
        3'd2: begin mq[i] = ((x * 2) + longint'(vsl)) & m; mf[i] = top[0]; end
        3'd3: begin mq[i] = (x / 2) + (longint'(vsr) << (w[i] - 1)); mf[i] = bot[0]; end
        3'd4: begin mq[i] = ((x * 2) + top) & m; mf[i] = top[0]; end
        3'd5: begin mq[i] = (x / 2) + (bot << (w[i] - 1)); mf[i] = bot[0]; end
        3'd6: begin mq[i] = (x + 1) & m; mf[i] = (x == m); end
        3'd7: begin mq[i] = (x + m) & m; mf[i] = (x == 0); end
        default: ;
      endcase
    end
  endtask
  task automatic cmp_one(input string tag, input int i, input longint unsigned q,
                         input logic f, input logic z, input logic sl, input logic sr);
    check({tag, ".q"}, q, mq[i]);
    check({tag, ".flag"}, f, mf[i]);
    check({tag, ".zero"}, z, mq[i] == 0);
    check({tag, ".sout_l"}, sl, (mq[i] >> (w[i] - 1)) & 1);
    check({tag, ".sout_r"}, sr, mq[i] & 1);
  endtask
  task automatic cmp_all();
    cmp_one("a", 0, a.q, a.flag, a.zero, a.sout_l, a.sout_r);
    cmp_one("b", 1, b.q, b.flag, b.zero, b.sout_l, b.sout_r);
    cmp_one("c", 2, c.q, c.flag, c.zero, c.sout_l, c.sout_r);
  endtask
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    cmp_all();
  endtask
  task automatic async_reset();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin mq[i] = rv[i]; mf[i] = 1'b0; end
    #1;
    cmp_all();
  endtask
  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 3'd1, 7'b0000111, 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin mq[i] = rv[i]; mf[i] = 1'b0; end
    #1;
    check("rst_q0", a.q, 7'h00);
    check("rst_f0", a.flag, 1'b0);
    check("rst_b_q0", b.q, 7'h55);
    #11;
    check("rst_q_hold", a.q, 7'h00);
    check("rst_f_hold", a.flag, 1'b0);
    cmp_all();
    #8;
    reset = 1'b0;
    tick();
    check("load_q", a.q, 7'b0000111);
    check("load_f", a.flag, 1'b0);
    check("load_zero", a.zero, 1'b0);
    drive(1'b1, 1'b0, 3'd1, 7'b1000001, 16'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 3'd2, 7'h0, 16'h0, 1'b1, 1'b0); tick();
    check("shl_q", a.q, 7'b0000011);
    check("shl_f", a.flag, 1'b1);
    drive(1'b1, 1'b0, 3'd3, 7'h0, 16'h0, 1'b0, 1'b0); tick();
    check("shr_q", a.q, 7'b0000001);
    check("shr_f", a.flag, 1'b1);
    drive(1'b1, 1'b0, 3'd5, 7'h0, 16'h0, 1'b0, 1'b0); tick();
    check("ror_q", a.q, 7'b1000000);
    check("ror_f", a.flag, 1'b1);
    check("ror_soutl", a.sout_l, 1'b1);
    drive(1'b1, 1'b0, 3'd1, 7'b1111110, 16'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 3'd6, 7'h0, 16'h0, 1'b0, 1'b0); tick();
    check("inc1_q", a.q, 7'b1111111);
    check("inc1_f", a.flag, 1'b0);
    tick();
    check("inc2_q", a.q, 7'b0000000);
    check("inc2_f", a.flag, 1'b1);
    check("inc2_zero", a.zero, 1'b1);
    drive(1'b1, 1'b0, 3'd7, 7'h0, 16'h0, 1'b0, 1'b0); tick();
    check("dec_q", a.q, 7'b1111111);
    check("dec_f", a.flag, 1'b1);
    drive(1'b1, 1'b0, 3'd1, 7'b0101010, 16'h0, 1'b0, 1'b0); tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 3'(k), 7'h7F, 16'hFFFF, 1'b1, 1'b1); tick();
      check("hold_q", a.q, 7'b0101010);
      check("hold_f", a.flag, 1'b0);
    end
    drive(1'b0, 1'b1, 3'd1, 7'h7F, 16'h0, 1'b0, 1'b0); tick();
    check("sclr_q", a.q, 7'h00);
    check("sclr_b_q", b.q, 7'h55);
    check("sclr_f", a.flag, 1'b0);
    drive(1'b1, 1'b0, 3'd1, 7'b1010101, 16'h0, 1'b0, 1'b0); tick();
    async_reset();
    check("midrst_q", a.q, 7'h00);
    check("midrst_b_q", b.q, 7'h55);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 3'd1, 7'h0, 16'hFFFF, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 3'd6, 7'h0, 16'h0, 1'b0, 1'b0); tick();
    check("w16_inc_q", c.q, 16'h0000);
    check("w16_inc_f", c.flag, 1'b1);
    drive(1'b1, 1'b0, 3'd1, 7'h0, 16'h8001, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 3'd4, 7'h0, 16'h0, 1'b0, 1'b0); tick();
    check("w16_rol_q", c.q, 16'h0003);
    check("w16_rol_f", c.flag, 1'b1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
        tick();
        reset = 1'b0;
      end else begin
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)),
              7'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        tick();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
